// File: rtl/mini_alu.sv
// Tiny 16-bit accumulator machine: a ROM program drives an LED register and a
// nibble-serial LCD port. Program selects one of the built-in ROM images.
//
//   state   | meaning
//   IDLE    | executing instructions, LCD port quiet
//   SEND_HI | high nibble presented, waiting for iLCD_response
//   GAP     | one-cycle strobe gap between nibbles
//   SEND_LO | low nibble presented, waiting for iLCD_response
module mini_alu #(
  parameter int Program = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  output logic [7:0] oLed,
  input  logic       iLCD_response,
  output logic [3:0] oLCD_data,
  output logic       oLCD_reset,
  output logic       oLCD_writeEN,
  output logic       oLCD_StrataFlashControl
);

  localparam logic [7:0] OpNop    = 8'd0;
  localparam logic [7:0] OpSto    = 8'd1;
  localparam logic [7:0] OpAdd    = 8'd2;
  localparam logic [7:0] OpSub    = 8'd3;
  localparam logic [7:0] OpLed    = 8'd4;
  localparam logic [7:0] OpJmp    = 8'd5;
  localparam logic [7:0] OpBle    = 8'd6;
  localparam logic [7:0] OpLcd    = 8'd7;
  localparam logic [7:0] OpLcdRst = 8'd8;

  typedef enum logic [1:0] {IDLE, SEND_HI, GAP, SEND_LO} lcdState_t;

  function automatic logic [31:0] romWord(input logic [7:0] addr);
    logic [31:0] w;
    w = {OpNop, 24'h0};
    if (Program == 1) begin
      case (addr)
        8'd0:    w = {OpSto, 8'h01, 16'h0005};
        8'd1:    w = {OpSto, 8'h02, 16'h0003};
        8'd2:    w = {OpSub, 8'h03, 8'h02, 8'h01};
        8'd3:    w = {OpLed, 8'h00, 8'h03, 8'h00};
        8'd4:    w = {OpBle, 8'h00, 8'h01, 8'h02};
        default: w = {OpNop, 24'h0};
      endcase
    end else if (Program == 2) begin
      case (addr)
        8'd1:    w = {OpLcdRst, 24'h0};
        8'd2:    w = 32'hFF01_1234;
        8'd3:    w = {OpLed, 8'h00, 8'h01, 8'h00};
        8'd4:    w = {OpJmp, 8'h04, 16'h0000};
        default: w = {OpNop, 24'h0};
      endcase
    end else begin
      case (addr)
        8'd1:    w = {OpSto, 8'h01, 16'h0001};
        8'd2:    w = {OpSto, 8'h02, 16'h0000};
        8'd3:    w = {OpSto, 8'h04, 16'h0048};
        8'd4:    w = {OpLcd, 8'h00, 8'h04, 8'h00};
        8'd5:    w = {OpLed, 8'h00, 8'h02, 8'h00};
        8'd6:    w = {OpAdd, 8'h02, 8'h02, 8'h01};
        8'd7:    w = {OpJmp, 8'h05, 16'h0000};
        default: w = {OpNop, 24'h0};
      endcase
    end
    return w;
  endfunction

  logic [7:0]  ip;
  logic [15:0] regs [16];
  logic [31:0] instr;
  logic [7:0]  op;
  logic [7:0]  dst;
  logic [15:0] imm;
  logic [15:0] src1Val;
  logic [15:0] src0Val;
  logic [7:0]  lcdChar;
  logic        rstFollow;
  lcdState_t   lcdState;

  always_comb begin
    instr   = romWord(ip);
    op      = instr[31:24];
    dst     = instr[23:16];
    imm     = instr[15:0];
    src1Val = regs[instr[11:8]];
    src0Val = regs[instr[3:0]];
  end

  assign oLCD_StrataFlashControl = 1'b1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ip           <= 8'd0;
      for (int i = 0; i < 16; i++) regs[i] <= 16'd0;
      oLed         <= 8'd0;
      oLCD_data    <= 4'd0;
      oLCD_writeEN <= 1'b0;
      oLCD_reset   <= 1'b1;
      rstFollow    <= 1'b1;
      lcdChar      <= 8'd0;
      lcdState     <= IDLE;
    end else begin
      // LCD reset stays up for the cycle after Reset drops
      rstFollow  <= 1'b0;
      oLCD_reset <= rstFollow;
      case (lcdState)
        IDLE: begin
          ip <= ip + 8'd1;
          case (op)
            OpSto: regs[dst[3:0]] <= imm;
            OpAdd: regs[dst[3:0]] <= src1Val + src0Val;
            OpSub: regs[dst[3:0]] <= src1Val - src0Val;
            OpLed: oLed <= src1Val[7:0];
            OpJmp: ip <= dst;
            OpBle: if (src1Val <= src0Val) ip <= dst;
            OpLcd: begin
              ip           <= ip;
              lcdChar      <= src1Val[7:0];
              oLCD_data    <= src1Val[7:4];
              oLCD_writeEN <= 1'b1;
              lcdState     <= SEND_HI;
            end
            OpLcdRst: oLCD_reset <= 1'b1;
            default: ;
          endcase
        end
        SEND_HI: begin
          if (iLCD_response) begin
            oLCD_data    <= 4'd0;
            oLCD_writeEN <= 1'b0;
            lcdState     <= GAP;
          end
        end
        GAP: begin
          oLCD_data    <= lcdChar[3:0];
          oLCD_writeEN <= 1'b1;
          lcdState     <= SEND_LO;
        end
        SEND_LO: begin
          if (iLCD_response) begin
            oLCD_data    <= 4'd0;
            oLCD_writeEN <= 1'b0;
            ip           <= ip + 8'd1;
            lcdState     <= IDLE;
          end
        end
        default: lcdState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_alu.sv
// Bench for mini_alu: default program (LCD handshake, LED counter), plus two
// alternate ROM images for SUB/BLE and LCDRST/undefined-opcode behaviour.
module tb_mini_alu;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       resp0;
  logic       respTie = 1'b0;

  logic [7:0] led0, led1, led2;
  logic [3:0] data0, data1, data2;
  logic       lrst0, lrst1, lrst2;
  logic       wen0, wen1, wen2;
  logic       flash0, flash1, flash2;

  int checks = 0;
  int errors = 0;

  // Character the default program sends, and the nibbles it should appear as
  localparam logic [7:0] LcdChar = 8'h48;
  logic [3:0] hiNib;
  logic [3:0] loNib;

  mini_alu #(.Program(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .oLed(led0), .iLCD_response(resp0),
    .oLCD_data(data0), .oLCD_reset(lrst0), .oLCD_writeEN(wen0),
    .oLCD_StrataFlashControl(flash0));

  mini_alu #(.Program(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .oLed(led1), .iLCD_response(respTie),
    .oLCD_data(data1), .oLCD_reset(lrst1), .oLCD_writeEN(wen1),
    .oLCD_StrataFlashControl(flash1));

  mini_alu #(.Program(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .oLed(led2), .iLCD_response(respTie),
    .oLCD_data(data2), .oLCD_reset(lrst2), .oLCD_writeEN(wen2),
    .oLCD_StrataFlashControl(flash2));

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // LED shows the count of completed increments, modulo the 8-bit register
  function automatic logic [7:0] ledModel(input int increments);
    return 8'(increments % 256);
  endfunction

  initial begin
    int n;
    hiNib = LcdChar[7:4];
    loNib = LcdChar[3:0];

    // ---------------- reset and default program, response tied high
    Reset = 1'b1;
    resp0 = 1'b1;
    tick();
    check("rst_ip", 32'(dut0.ip), 32'd0);
    check("rst_led", 32'(led0), 32'd0);
    check("rst_wen", 32'(wen0), 32'd0);
    check("rst_data", 32'(data0), 32'd0);
    check("rst_lcdreset", 32'(lrst0), 32'd1);
    check("rst_flash", 32'(flash0), 32'd1);
    Reset = 1'b0;

    tick(); // E1
    check("lcdreset_follow", 32'(lrst0), 32'd1);
    tick(); // E2
    check("lcdreset_drop", 32'(lrst0), 32'd0);
    check("lcdrst_instr", 32'(lrst2), 32'd1);
    tick(); // E3
    check("lcdrst_one_cycle", 32'(lrst2), 32'd0);
    tick(); // E4
    check("e4_ip", 32'(dut0.ip), 32'd4);
    check("e4_wen", 32'(wen0), 32'd0);
    check("sub_wrap_led", 32'(led1), 32'h0FE);
    check("undef_nop_led", 32'(led2), 32'd0);
    check("undef_nop_ip", 32'(dut2.ip), 32'd4);
    tick(); // E5
    check("e5_wen", 32'(wen0), 32'd1);
    check("e5_data", 32'(data0), 32'(hiNib));
    check("ble_not_taken_ip", 32'(dut1.ip), 32'd5);
    check("alt2_wen", 32'(wen2), 32'd0);
    tick(); // E6
    check("e6_wen", 32'(wen0), 32'd0);
    check("e6_data", 32'(data0), 32'd0);
    tick(); // E7
    check("e7_wen", 32'(wen0), 32'd1);
    check("e7_data", 32'(data0), 32'(loNib));
    tick(); // E8
    check("e8_wen", 32'(wen0), 32'd0);
    check("e8_data", 32'(data0), 32'd0);
    check("e8_ip", 32'(dut0.ip), 32'd5);
    tick(); // E9
    check("e9_led", 32'(led0), 32'(ledModel(0)));
    repeat (3) tick(); // E12
    check("e12_led", 32'(led0), 32'(ledModel(1)));
    repeat (3) tick(); // E15
    check("e15_led", 32'(led0), 32'(ledModel(2)));

    for (int j = 3; j <= 256; j++) begin
      repeat (3) tick();
      if (j == 256 || $urandom_range(0, 15) == 0)
        check($sformatf("led_count_%0d", j), 32'(led0), 32'(ledModel(j)));
    end

    // ---------------- stalled handshake with random hold times
    Reset = 1'b1;
    resp0 = 1'b0;
    tick();
    Reset = 1'b0;
    repeat (5) tick(); // E5: SEND_HI entered
    n = $urandom_range(3, 30);
    for (int k = 0; k < n; k++) begin
      check("stall_hi_wen", 32'(wen0), 32'd1);
      check("stall_hi_data", 32'(data0), 32'(hiNib));
      check("stall_hi_ip", 32'(dut0.ip), 32'd4);
      check("stall_hi_led", 32'(led0), 32'd0);
      tick();
    end
    resp0 = 1'b1;
    tick();
    check("gap_wen", 32'(wen0), 32'd0);
    check("gap_data", 32'(data0), 32'd0);
    // response left high through GAP must not shorten the low nibble
    tick();
    resp0 = 1'b0;
    check("lo_wen", 32'(wen0), 32'd1);
    check("lo_data", 32'(data0), 32'(loNib));
    n = $urandom_range(2, 20);
    for (int k = 0; k < n; k++) begin
      tick();
      check("stall_lo_wen", 32'(wen0), 32'd1);
      check("stall_lo_data", 32'(data0), 32'(loNib));
      check("stall_lo_ip", 32'(dut0.ip), 32'd4);
    end

    // ---------------- reset aborts a transfer in SEND_LO
    Reset = 1'b1;
    tick();
    check("abort_wen", 32'(wen0), 32'd0);
    check("abort_data", 32'(data0), 32'd0);
    check("abort_ip", 32'(dut0.ip), 32'd0);
    check("abort_led", 32'(led0), 32'd0);
    check("abort_lcdreset", 32'(lrst0), 32'd1);
    check("abort_flash", 32'(flash0), 32'd1);
    Reset = 1'b0;
    resp0 = 1'b1;
    tick();
    check("abort_follow", 32'(lrst0), 32'd1);
    check("abort_ip1", 32'(dut0.ip), 32'd1);
    tick();
    check("abort_drop", 32'(lrst0), 32'd0);
    check("flash_all", 32'({flash0, flash1, flash2}), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mini_alu.md
MINI_ALU -- requirements
Module: MiniAlu

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports named Clock and Reset.
REQ-002 Clock, input, 1: rising-edge system clock.
REQ-003 Reset, input, 1: synchronous active-high reset, sampled on the Clock rising edge.
REQ-004 oLed, output, 8: LED register.
REQ-005 iLCD_response, input, 1: LCD controller acknowledge, high for one or more cycles when the current nibble is accepted.
REQ-006 oLCD_data, output, 4: nibble sent to the LCD controller.
REQ-007 oLCD_reset, output, 1: LCD controller reset request.
REQ-008 oLCD_writeEN, output, 1: nibble-valid strobe to the LCD controller.
REQ-009 oLCD_StrataFlashControl, output, 1: held constant 1 to disable the shared StrataFlash.

Function
REQ-010 The block SHALL contain an 8-bit instruction pointer (IP), a 256x32 combinational-read program ROM, and sixteen 16-bit registers R0-R15.
REQ-011 The instruction word SHALL be {op[31:24], dst[23:16], src1[15:8], src0[7:0]}; register indices use the low 4 bits of each field; imm16 = {src1,src0}.
REQ-012 Every non-stalling instruction SHALL complete on one rising edge, with IP <= IP+1 unless it jumps.
REQ-013 Opcodes SHALL be as follows: 0 NOP; 1 STO R[dst] <= imm16; 2 ADD R[dst] <= R[src1]+R[src0], mod 2^16; 3 SUB R[dst] <= R[src1]-R[src0], mod 2^16, wrapping; 4 LED oLed <= R[src1][7:0]; 5 JMP IP <= dst; 6 BLE IP <= dst if unsigned R[src1] <= R[src0], else IP+1; 7 LCD, sends R[src1][7:0]; 8 LCDRST oLCD_reset = 1 for exactly one cycle.
REQ-014 Undefined opcodes SHALL execute as NOP.
REQ-015 IP SHALL wrap from 255 to 0.
REQ-016 LCD SHALL be a stalling instruction run by an FSM with states IDLE, SEND_HI, GAP and SEND_LO, and IP held until the FSM completes.
REQ-017 IDLE with LCD fetched SHALL go to SEND_HI at the next edge, driving oLCD_writeEN=1 and oLCD_data=char[7:4].
REQ-018 SEND_HI SHALL hold its outputs until iLCD_response=1 is sampled, then go to GAP.
REQ-019 GAP SHALL last exactly one cycle with oLCD_writeEN=0, then go to SEND_LO.
REQ-020 SEND_LO SHALL drive oLCD_writeEN=1 and oLCD_data=char[3:0] until iLCD_response=1 is sampled, then set IP <= IP+1 and go to IDLE with oLCD_writeEN=0.
REQ-021 iLCD_response SHALL be ignored in IDLE and GAP.
REQ-022 oLCD_data SHALL be 0 whenever oLCD_writeEN=0.
REQ-023 The ROM default program SHALL be: 0 NOP; 1 STO R1,1; 2 STO R2,0; 3 STO R4,0x0048; 4 LCD src1=R4; 5 LED src1=R2; 6 ADD R2,R2,R1; 7 JMP 5; all other addresses NOP.

Reset
REQ-024 While Reset=1 is sampled, the block SHALL set IP=0, all registers R0-R15=0, oLed=0, oLCD_data=0, oLCD_writeEN=0 and FSM=IDLE.
REQ-025 oLCD_reset SHALL be 1 during any cycle in which Reset=1 is sampled and for the following cycle.
REQ-026 Reset SHALL take priority over everything, including aborting an in-progress LCD transfer.
REQ-027 oLCD_StrataFlashControl SHALL equal 1 at all times.

Verification
REQ-028 Reset 1 cycle, iLCD_response tied 1 -> edges E1-E4 run addresses 0-3; after E5 writeEN=1 and data=4; after E6 writeEN=0; after E7 writeEN=1 and data=8; after E8 writeEN=0 and IP=5.
REQ-029 Continuing REQ-028 -> oLed=0 after E9, 1 after E12, 2 after E15 (3-cycle period); after 256 increments oLed wraps to 0.
REQ-030 iLCD_response held 0 -> SEND_HI persists with writeEN=1 and data=4, IP=4, oLed=0 indefinitely; raising iLCD_response for 1 cycle advances to GAP.
REQ-031 Reset asserted while in SEND_LO -> next cycle writeEN=0, data=0, IP=0, oLed=0, oLCD_reset=1; oLCD_StrataFlashControl=1 throughout.
REQ-032 Alternate ROM: STO R1,5; STO R2,3; SUB R3,R2,R1; LED R3; BLE 0,R1,R2 -> oLed=0xFE (0xFFFE truncated); BLE not taken because 5 > 3, so IP=5.
REQ-033 Alternate ROM: LCDRST at address 1 -> oLCD_reset=1 for exactly one cycle after that edge; undefined opcode 0xFF behaves as NOP.
